// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB4 command-port master.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    // Slave-index field width; a single slave still needs one bit.
    function automatic int calc_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_strb_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a byte address to a one-hot slave select; indices past the last slave flag a decode error.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int SLV_SEL_LSB = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  decode_err
);

    localparam int SEL_W = calc_sel_w(NUM_SLAVES);

    logic [SEL_W-1:0] idx;
    logic             unused_addr;

    assign idx         = addr[SLV_SEL_LSB +: SEL_W];
    assign unused_addr = ^addr;

    always_comb begin
        sel        = '0;
        decode_err = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == SEL_W'(i)) begin
                sel[i]     = 1'b1;
                decode_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_master_mux.sv
// APB4 master: one command at a time from a valid/ready port onto a shared multi-slave APB bus,
// with decode-error and PREADY-timeout handling and a held valid/ready response.
module apb_master_mux
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLV_SEL_LSB    = 12,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH    = calc_strb_w(DATA_WIDTH)
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    input  logic [STRB_WIDTH-1:0]            cmd_strb,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [STRB_WIDTH-1:0]            PSTRB,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    apb_state_e                state;
    logic [CNT_W-1:0]          wait_cnt;
    logic [NUM_SLAVES-1:0]     dec_sel;
    logic                      dec_err;
    logic                      sel_rdy;
    logic                      sel_err;
    logic [DATA_WIDTH-1:0]     sel_rdata;

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_SEL_LSB(SLV_SEL_LSB)
    ) u_dec (
        .addr      (cmd_addr),
        .sel       (dec_sel),
        .decode_err(dec_err)
    );

    // PSEL is one-hot while a transfer is live, so masking picks the addressed slave only.
    assign sel_rdy = |(PREADY & PSEL);
    assign sel_err = |(PSLVERR & PSEL);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL[i]) sel_rdata |= PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= RSP_OK;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (dec_err) begin
                            // Nothing to address: answer straight away without touching the bus.
                            state       <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= RSP_ERR;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                        end else begin
                            state  <= ST_SETUP;
                            PSEL   <= dec_sel;
                            PADDR  <= cmd_addr;
                            PWRITE <= cmd_write;
                            PWDATA <= cmd_write ? cmd_wdata : '0;
                            PSTRB  <= cmd_write ? cmd_strb : '0;
                        end
                    end
                end
                ST_SETUP: begin
                    state    <= ST_ACCESS;
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                end
                ST_ACCESS: begin
                    if (sel_rdy) begin
                        state       <= ST_RESP;
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= sel_err ? RSP_ERR : RSP_OK;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!PWRITE && !sel_err) ? sel_rdata : '0;
                    end else if (TIMEOUT_CYCLES != 0 &&
                                 wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= ST_RESP;
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= RSP_ERR;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    PSEL      <= '0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_mux.sv
// Randomised bench: two masters (4 slaves/timeout 8, 3 slaves/default timeout) against a transaction-level model.
module tb_apb_master_mux;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        sel_b;
    logic        cmd_valid, cmd_write, rsp_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;

    logic a_cmd_valid, b_cmd_valid;
    logic a_cmd_ready, a_rsp_valid, a_rsp_err, a_rsp_timeout, a_penable, a_pwrite;
    logic b_cmd_ready, b_rsp_valid, b_rsp_err, b_rsp_timeout, b_penable, b_pwrite;
    logic [31:0]  a_rsp_rdata, a_paddr, a_pwdata, b_rsp_rdata, b_paddr, b_pwdata;
    logic [3:0]   a_pstrb, b_pstrb;
    logic [3:0]   a_psel, a_pready, a_pslverr;
    logic [2:0]   b_psel, b_pready, b_pslverr;
    logic [127:0] a_prdata;
    logic [95:0]  b_prdata;

    int          errs = 0;
    int          checks = 0;
    int          acc_cnt = 0;
    int          wait_cfg = 0;
    logic        err_cfg = 1'b0;
    logic [31:0] rd_cfg [4];
    logic [3:0]  junk_rdy = '0, junk_err = '0;

    always #5 PCLK = ~PCLK;

    assign a_cmd_valid = cmd_valid & ~sel_b;
    assign b_cmd_valid = cmd_valid & sel_b;

    apb_master_mux #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(8)) u_a (
        .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel_b), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .rsp_timeout(a_rsp_timeout), .PSEL(a_psel), .PENABLE(a_penable),
        .PWRITE(a_pwrite), .PADDR(a_paddr), .PWDATA(a_pwdata), .PSTRB(a_pstrb),
        .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
    );

    apb_master_mux #(.NUM_SLAVES(3)) u_b (
        .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel_b), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .rsp_timeout(b_rsp_timeout), .PSEL(b_psel), .PENABLE(b_penable),
        .PWRITE(b_pwrite), .PADDR(b_paddr), .PWDATA(b_pwdata), .PSTRB(b_pstrb),
        .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
    );

    // View of whichever master is under test.
    logic [3:0]  m_psel, m_pstrb;
    logic [31:0] m_paddr, m_pwdata, m_rdata;
    logic        m_penable, m_pwrite, m_cmd_ready, m_rsp_valid, m_rsp_err, m_rsp_to;
    assign m_psel      = sel_b ? {1'b0, b_psel} : a_psel;
    assign m_pstrb     = sel_b ? b_pstrb : a_pstrb;
    assign m_paddr     = sel_b ? b_paddr : a_paddr;
    assign m_pwdata    = sel_b ? b_pwdata : a_pwdata;
    assign m_rdata     = sel_b ? b_rsp_rdata : a_rsp_rdata;
    assign m_penable   = sel_b ? b_penable : a_penable;
    assign m_pwrite    = sel_b ? b_pwrite : a_pwrite;
    assign m_cmd_ready = sel_b ? b_cmd_ready : a_cmd_ready;
    assign m_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_err   = sel_b ? b_rsp_err : a_rsp_err;
    assign m_rsp_to    = sel_b ? b_rsp_timeout : a_rsp_timeout;

    // Slave model: the addressed slave answers after wait_cfg access cycles; the others show junk.
    always @(posedge PCLK) acc_cnt <= (m_psel != 0 && m_penable) ? acc_cnt + 1 : 0;

    always_comb begin
        a_pready = '0; a_pslverr = '0; a_prdata = '0;
        b_pready = '0; b_pslverr = '0; b_prdata = '0;
        for (int i = 0; i < 4; i++) begin
            a_pready[i]         = a_psel[i] ? (acc_cnt >= wait_cfg) : junk_rdy[i];
            a_pslverr[i]        = a_psel[i] ? err_cfg : junk_err[i];
            a_prdata[i*32 +: 32] = rd_cfg[i];
        end
        for (int i = 0; i < 3; i++) begin
            b_pready[i]         = b_psel[i] ? (acc_cnt >= wait_cfg) : junk_rdy[i];
            b_pslverr[i]        = b_psel[i] ? err_cfg : junk_err[i];
            b_prdata[i*32 +: 32] = rd_cfg[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input bit b, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input int waits,
                           input bit serr, input logic [31:0] rdat, input int hold);
        int          idx, ns, to, exp_lat, k;
        bit          dec, tmo, exp_err;
        logic [31:0] exp_rdata;
        idx = int'(addr[13:12]);
        ns  = b ? 3 : 4;
        to  = b ? 256 : 8;
        dec = idx >= ns;
        tmo = !dec && waits >= to;
        exp_err   = dec || tmo || serr;
        exp_lat   = dec ? 1 : (tmo ? 2 + to : 3 + waits);
        @(negedge PCLK);
        sel_b    = b;
        wait_cfg = waits;
        err_cfg  = serr;
        for (int i = 0; i < 4; i++) rd_cfg[i] = $urandom;
        if (!dec) rd_cfg[idx] = rdat;
        junk_rdy = 4'($urandom);
        junk_err = 4'($urandom);
        exp_rdata = (!wr && !exp_err) ? rdat : 32'h0;
        #1;
        chk("cmd_ready_idle", m_cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom);
        k = 0;
        do begin
            @(negedge PCLK);
            k++;
            if (k == 1) begin
                chk("cmd_ready_busy", m_cmd_ready, 0);
                chk("psel_t1", m_psel, dec ? 4'h0 : 4'(1 << idx));
                if (!dec) begin
                    chk("penable_setup", m_penable, 0);
                    chk("paddr", m_paddr, addr);
                    chk("pwrite", m_pwrite, wr);
                    chk("pwdata", m_pwdata, wr ? wdata : 32'h0);
                    chk("pstrb_setup", m_pstrb, wr ? strb : 4'h0);
                end
            end
            if (k == 2 && !dec) begin
                chk("penable_access", m_penable, 1);
                chk("pstrb_access", m_pstrb, wr ? strb : 4'h0);
            end
        end while (!m_rsp_valid && k < 300);
        chk("latency", k, exp_lat);
        chk("rsp_err", m_rsp_err, exp_err);
        chk("rsp_timeout", m_rsp_to, tmo);
        chk("rsp_rdata", m_rdata, exp_rdata);
        chk("bus_idle_rsp", {m_psel, m_penable}, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge PCLK);
            chk("rsp_hold", {m_rsp_valid, m_cmd_ready, m_rsp_err, m_rsp_to, m_rdata},
                {1'b1, 1'b0, exp_err, tmo, exp_rdata});
        end
        rsp_ready = 1'b1;
        @(posedge PCLK);
        #1 rsp_ready = 1'b0;
        @(negedge PCLK);
        chk("rsp_done", {m_rsp_valid, m_cmd_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        for (int i = 0; i < 4; i++) rd_cfg[i] = '0;
        PRESET = 1'b1; sel_b = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; rsp_ready = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_cmd_ready", a_cmd_ready, 1);
        chk("rst_bus", {a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_pstrb}, 0);
        chk("rst_rsp", {a_rsp_valid, a_rsp_rdata, a_rsp_err, a_rsp_timeout}, 0);
        chk("rst_b", {b_cmd_ready, b_psel, b_rsp_valid}, {1'b1, 3'b0, 1'b0});

        run_txn(0, 1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 0);
        run_txn(0, 0, 32'h0000_2000, 32'h0, 4'h0, 3, 0, 32'h1234_5678, 0);
        run_txn(1, 0, 32'h0000_3000, 32'h0, 4'h0, 0, 0, 32'h0, 0);
        run_txn(0, 0, 32'h0000_0010, 32'h0, 4'h0, 255, 0, 32'h0, 0);
        run_txn(0, 0, 32'h0000_3000, 32'h0, 4'h0, 0, 1, 32'hA5A5_A5A5, 5);
        run_txn(1, 0, 32'h0000_2008, 32'h0, 4'h0, 1, 0, 32'hCAFE_F00D, 1);

        // Reset in the middle of an ACCESS wait.
        @(negedge PCLK);
        sel_b = 1'b0; wait_cfg = 255; err_cfg = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("pre_rst_access", {a_psel, a_penable}, 5'b0001_1);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        chk("mid_rst_state", {a_psel, a_penable, a_rsp_valid, a_cmd_ready, a_paddr},
            {4'b0, 1'b0, 1'b0, 1'b1, 32'h0});
        quiet = 0;
        repeat (12) begin
            @(negedge PCLK);
            if (a_rsp_valid || a_psel != 0) quiet++;
        end
        chk("mid_rst_no_rsp", quiet, 0);

        for (int n = 0; n < 40; n++) begin
            bit b, wr, serr;
            int waits;
            b     = ($urandom_range(0, 3) == 0);
            wr    = 1'($urandom);
            serr  = ($urandom_range(0, 3) == 0);
            waits = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 4);
            run_txn(b, wr, $urandom, $urandom, 4'($urandom), waits, serr, $urandom,
                    $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
